// File: rtl/rr_arbiter_8x.sv
// rr_arbiter_8x
// Round-robin arbiter sharing one resource among eight requesters.
// A grant is held until its owner drops the request or MAX_HOLD
// consecutive cycles have elapsed. After either release the search
// pointer moves one past the released owner, so the released owner
// becomes the lowest priority. Every grant is followed by at least
// one idle cycle.
//
// Parameters:
//   MAX_HOLD  : maximum consecutive grant cycles (1..255), default 4
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   req[7:0]  : request vector, bit i = requester i wants the resource
//   gnt[7:0]  : registered one-hot grant (zero when no grant is active)
//   gnt_idx   : binary index of the current or last granted requester
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse after a grant is force-released

module rr_arbiter_8x #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [2:0] winner;
    logic [2:0] release_ptr;

    function automatic logic [7:0] decode3(input logic [2:0] idx);
        decode3 = 8'b0000_0001 << idx;
    endfunction

    // Rotating priority search. Offsets are scanned from farthest to
    // nearest so the last hit (the smallest offset from ptr) wins.
    always_comb begin
        logic [2:0] cand;
        winner = ptr;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr + 3'(i);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    // Pointer after any release: one past the owner, wrapping 7 -> 0.
    assign release_ptr = gnt_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt_idx   <= 3'd0;
            hold_cnt  <= 8'd0;
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_idx   <= winner;
                        hold_cnt  <= 8'd1;
                        gnt       <= decode3(winner);
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[gnt_idx]) begin
                        state     <= IDLE;
                        ptr       <= release_ptr;
                        gnt       <= 8'd0;
                        gnt_valid <= 1'b0;
                    end else if (hold_cnt == HOLD_LIMIT) begin
                        // Forced release: the owner is still requesting.
                        state     <= IDLE;
                        ptr       <= release_ptr;
                        gnt       <= 8'd0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 8'd0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8x.sv
// Testbench for rr_arbiter_8x.
// A stimulus process drives rst/req once per cycle (on the falling edge),
// advances a behavioural reference model and queues the outputs expected
// after the next rising edge. A separate monitor pops that queue shortly
// after each rising edge and compares it with the DUT outputs.

module tb_rr_arbiter_8x;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Reference model state, kept in plain integer terms.
    int m_owner = -1;  // current owner, -1 when nobody holds the resource
    int m_last  = 0;   // most recently granted index
    int m_start = 0;   // index with highest priority for the next search
    int m_held  = 0;   // cycles the current owner has held the grant
    int m_to    = 0;   // timeout pulse visible after this edge

    rr_arbiter_8x #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge of the arbiter rules, applied to the model.
    task automatic model_step(input logic r, input logic [7:0] q);
        int k;
        if (r) begin
            m_owner = -1;
            m_last  = 0;
            m_start = 0;
            m_held  = 0;
            m_to    = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            if (q != 8'd0) begin
                k = 0;
                while (q[(m_start + k) % 8] == 1'b0) k++;
                m_owner = (m_start + k) % 8;
                m_last  = m_owner;
                m_held  = 1;
            end
        end else if (q[m_owner] == 1'b0) begin
            m_start = (m_owner + 1) % 8;
            m_owner = -1;
            m_to    = 0;
        end else if (m_held == MAX_HOLD) begin
            m_start = (m_owner + 1) % 8;
            m_owner = -1;
            m_to    = 1;
        end else begin
            m_held++;
            m_to = 0;
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [7:0] q, input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            rst = r;
            req = q;
            model_step(r, q);
            e.gnt   = (m_owner >= 0) ? (8'b0000_0001 << m_owner) : 8'd0;
            e.idx   = 3'(m_last);
            e.valid = (m_owner >= 0);
            e.to    = (m_to != 0);
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cycle, act, want);
        end
    endtask

    // Monitor: compares every presented output set against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard_empty cycle=%0d got=none want=entry", cycle);
            end else begin
                e = exp_q.pop_front();
                check_output("gnt", gnt, e.gnt);
                check_output("gnt_idx", {5'd0, gnt_idx}, {5'd0, e.idx});
                check_output("gnt_valid", {7'd0, gnt_valid}, {7'd0, e.valid});
                check_output("timeout", {7'd0, timeout}, {7'd0, e.to});
            end
        end
    end

    initial begin
        logic [7:0] cur;
        logic       r;

        // Reset with everyone requesting, then first grant goes to 0.
        apply_stimulus(1'b1, 8'hFF, 2);
        apply_stimulus(1'b0, 8'hFF, 1);
        apply_stimulus(1'b0, 8'h00, 2);

        // Single request dropped early.
        apply_stimulus(1'b0, 8'b0010_0000, 2);
        apply_stimulus(1'b0, 8'h00, 2);

        // Full rotation with everyone requesting from ptr 0.
        apply_stimulus(1'b1, 8'h00, 1);
        apply_stimulus(1'b0, 8'hFF, 9 * (MAX_HOLD + 1) + 2);
        apply_stimulus(1'b0, 8'h00, 2);

        // Wrap: grant 6, release, then 7 beats 0, then 0 after wrap.
        apply_stimulus(1'b1, 8'h00, 1);
        apply_stimulus(1'b0, 8'b0100_0000, 2);
        apply_stimulus(1'b0, 8'h00, 1);
        apply_stimulus(1'b0, 8'b1000_0001, 2);
        apply_stimulus(1'b0, 8'b0000_0001, 3);
        apply_stimulus(1'b0, 8'h00, 2);

        // No preemption: index 2 keeps the grant while req[0] rises.
        apply_stimulus(1'b1, 8'h00, 1);
        apply_stimulus(1'b0, 8'b0000_0100, 2);
        apply_stimulus(1'b0, 8'b0000_0101, MAX_HOLD + 4);
        apply_stimulus(1'b0, 8'h00, 2);

        // Reset during the third cycle of a grant to index 4.
        apply_stimulus(1'b1, 8'h00, 1);
        apply_stimulus(1'b0, 8'b0001_0000, 3);
        apply_stimulus(1'b1, 8'b0001_0001, 1);
        apply_stimulus(1'b0, 8'b0001_0001, 3);
        apply_stimulus(1'b0, 8'h00, 2);

        // Randomised traffic with sticky request patterns and rare resets.
        cur = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) cur = 8'($urandom);
            if ($urandom_range(0, 7) == 0) cur = cur & ~(8'b0000_0001 << $urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) cur = 8'hFF;
            r = ($urandom_range(0, 99) == 0);
            apply_stimulus(r, cur, 1);
        end

        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
